// File: rtl/logo_bounce_ctrl.sv
// Bouncing-logo screen saver: moves a LOGO_SZ square around the active area and turns the raster
// position into logo ROM row addresses plus a per-pixel on/off bit, two clocks behind the raster.
module logo_bounce_ctrl #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int LOGO_SZ   = 128,
    parameter int STEP      = 1,
    parameter int FRAME_DIV = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic         frame_start,
    input  logic [10:0]  pix_x,
    input  logic [10:0]  pix_y,
    input  logic         pix_de,
    output logic [7:0]   rom_addr,
    input  logic [127:0] rom_q,
    output logic         pix_on,
    output logic         pix_de_out,
    output logic [10:0]  logo_x,
    output logic [10:0]  logo_y
);

    localparam int COL_W = $clog2(LOGO_SZ);
    localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    localparam logic [10:0]      MAX_X    = 11'(H_ACTIVE - LOGO_SZ);
    localparam logic [10:0]      MAX_Y    = 11'(V_ACTIVE - LOGO_SZ);
    localparam logic [10:0]      STEP_V   = 11'(STEP);
    localparam logic [10:0]      SZ_V     = 11'(LOGO_SZ);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(LOGO_SZ - 1);

    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_t;

    dir_t             dir_x_q, dir_x_d;
    dir_t             dir_y_q, dir_y_d;
    logic [10:0]      logo_x_q, logo_x_d;
    logic [10:0]      logo_y_q, logo_y_d;
    logic [DIV_W-1:0] div_q, div_d;

    logic [7:0]       rom_addr_q, rom_addr_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             box_q, box_d;
    logic             de_q, de_d;
    logic             pix_on_q, pix_on_d;
    logic             pix_de_out_q, pix_de_out_d;

    logic [10:0]      dx, dy;
    logic             in_box;
    logic             update;
    logic [COL_W-1:0] bit_idx;
    logic [11:0]      nx, ny;

    // Returns {reverse_to_negative, new_position} for one axis; the edge itself is a landing spot.
    function automatic logic [11:0] next_axis(input logic [10:0] pos, input logic dir_neg,
                                              input logic [10:0] max_pos);
        logic [11:0] r;
        if (!dir_neg) begin
            if (pos + STEP_V >= max_pos) r = {1'b1, max_pos};
            else                         r = {1'b0, pos + STEP_V};
        end else begin
            if (pos <= STEP_V) r = {1'b0, 11'd0};
            else               r = {1'b1, pos - STEP_V};
        end
        return r;
    endfunction

    always_comb begin
        dx      = pix_x - logo_x_q;
        dy      = pix_y - logo_y_q;
        in_box  = pix_de & (dx < SZ_V) & (dy < SZ_V);

        rom_addr_d   = in_box ? 8'(dy[COL_W-1:0]) : rom_addr_q;
        col_d        = dx[COL_W-1:0];
        box_d        = in_box;
        de_d         = pix_de;

        bit_idx      = COL_LAST - col_q;
        pix_on_d     = box_q & rom_q[bit_idx];
        pix_de_out_d = de_q;
    end

    // Motion: divider counts enabled frame pulses; the wrapping pulse also moves the logo.
    always_comb begin
        div_d    = div_q;
        logo_x_d = logo_x_q;
        logo_y_d = logo_y_q;
        dir_x_d  = dir_x_q;
        dir_y_d  = dir_y_q;
        update   = enable & frame_start & (div_q == DIV_LAST);
        nx       = next_axis(logo_x_q, dir_x_q == DIR_NEG, MAX_X);
        ny       = next_axis(logo_y_q, dir_y_q == DIR_NEG, MAX_Y);

        if (enable && frame_start) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        end
        if (update) begin
            logo_x_d = nx[10:0];
            logo_y_d = ny[10:0];
            dir_x_d  = nx[11] ? DIR_NEG : DIR_POS;
            dir_y_d  = ny[11] ? DIR_NEG : DIR_POS;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_x_q      <= DIR_POS;
            dir_y_q      <= DIR_POS;
            logo_x_q     <= '0;
            logo_y_q     <= '0;
            div_q        <= '0;
            rom_addr_q   <= '0;
            col_q        <= '0;
            box_q        <= 1'b0;
            de_q         <= 1'b0;
            pix_on_q     <= 1'b0;
            pix_de_out_q <= 1'b0;
        end else begin
            dir_x_q      <= dir_x_d;
            dir_y_q      <= dir_y_d;
            logo_x_q     <= logo_x_d;
            logo_y_q     <= logo_y_d;
            div_q        <= div_d;
            rom_addr_q   <= rom_addr_d;
            col_q        <= col_d;
            box_q        <= box_d;
            de_q         <= de_d;
            pix_on_q     <= pix_on_d;
            pix_de_out_q <= pix_de_out_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign pix_on     = pix_on_q;
    assign pix_de_out = pix_de_out_q;
    assign logo_x     = logo_x_q;
    assign logo_y     = logo_y_q;

endmodule

// File: tb/tb_logo_bounce_ctrl.sv
// Randomized bench for logo_bounce_ctrl: a bitmap ROM plus a position/pipeline reference model
// that follows the bounce rules with plain integer arithmetic.
module tb_logo_bounce_ctrl;

    localparam int STEP      = 4;
    localparam int FRAME_DIV = 2;
    localparam int SZ        = 128;
    localparam int MAX_X     = 640 - SZ;
    localparam int MAX_Y     = 480 - SZ;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic         frame_start;
    logic [10:0]  pix_x;
    logic [10:0]  pix_y;
    logic         pix_de;
    logic [7:0]   rom_addr;
    logic [127:0] rom_q;
    logic         pix_on;
    logic         pix_de_out;
    logic [10:0]  logo_x;
    logic [10:0]  logo_y;

    logic [127:0] bitmap [SZ];

    int total = 0;
    int bad   = 0;

    // reference model state
    int   mx, my, mdx, mdy, mcount;
    int   m_rom;
    logic pipe_on, pipe_de;
    logic exp_on, exp_de;

    logo_bounce_ctrl #(
        .H_ACTIVE (640),
        .V_ACTIVE (480),
        .LOGO_SZ  (SZ),
        .STEP     (STEP),
        .FRAME_DIV(FRAME_DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .frame_start(frame_start),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_de     (pix_de),
        .rom_addr   (rom_addr),
        .rom_q      (rom_q),
        .pix_on     (pix_on),
        .pix_de_out (pix_de_out),
        .logo_x     (logo_x),
        .logo_y     (logo_y)
    );

    always #5 clk = ~clk;

    assign rom_q = bitmap[rom_addr[6:0]];

    task automatic checkOutput(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        mx = 0; my = 0; mdx = 1; mdy = 1; mcount = 0;
        m_rom = 0; pipe_on = 1'b0; pipe_de = 1'b0;
    endtask

    // One position update: move, clamp into the active area, turn round on touching an edge.
    task automatic modelMove();
        mx = mx + mdx * STEP;
        if (mx >= MAX_X) begin mx = MAX_X; mdx = -1; end
        else if (mx <= 0) begin mx = 0; mdx = 1; end
        my = my + mdy * STEP;
        if (my >= MAX_Y) begin my = MAX_Y; mdy = -1; end
        else if (my <= 0) begin my = 0; mdy = 1; end
    endtask

    // Drive one raster cycle, clock it, advance the model and compare every output.
    task automatic applyStimulus(input logic fs, input logic en, input int px, input int py,
                                 input logic de);
        logic in_box;
        logic now_on;
        frame_start = fs;
        enable      = en;
        pix_x       = px[10:0];
        pix_y       = py[10:0];
        pix_de      = de;
        in_box = de && (px >= mx) && (px < mx + SZ) && (py >= my) && (py < my + SZ);
        now_on = 1'b0;
        if (in_box) now_on = bitmap[py - my][SZ - 1 - (px - mx)];
        @(posedge clk);
        #1;
        exp_on  = pipe_on;
        exp_de  = pipe_de;
        pipe_on = now_on;
        pipe_de = de;
        if (in_box) m_rom = py - my;
        if (fs && en) begin
            mcount++;
            if (mcount % FRAME_DIV == 0) modelMove();
        end
        checkOutput("pix_on", pix_on, exp_on);
        checkOutput("pix_de_out", pix_de_out, exp_de);
        checkOutput("rom_addr", rom_addr, m_rom);
        checkOutput("logo_x", logo_x, mx);
        checkOutput("logo_y", logo_y, my);
    endtask

    task automatic randomRun(input int cycles);
        logic prev_fs = 1'b0;
        logic fs;
        int   px, py;
        for (int i = 0; i < cycles; i++) begin
            fs = !prev_fs && ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 1) == 0) begin
                px = (mx - 4 + int'($urandom_range(0, SZ + 8))) & 2047;
                py = (my - 4 + int'($urandom_range(0, SZ + 8))) & 2047;
            end else begin
                px = int'($urandom_range(0, 799));
                py = int'($urandom_range(0, 524));
            end
            applyStimulus(fs, $urandom_range(0, 7) != 0, px, py, $urandom_range(0, 4) != 0);
            prev_fs = fs;
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; frame_start = 1'b0;
        pix_x = '0; pix_y = '0; pix_de = 1'b0;
        for (int r = 0; r < SZ; r++) bitmap[r] = {$urandom, $urandom, $urandom, $urandom};
        bitmap[3][114] = 1'b0;
        bitmap[3][113] = 1'b1;
        bitmap[3][112] = 1'b1;
        bitmap[3][111] = 1'b1;
        modelReset();

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_pix_on", pix_on, 0);
        checkOutput("rst_rom_addr", rom_addr, 0);
        checkOutput("rst_logo_x", logo_x, 0);
        checkOutput("rst_logo_y", logo_y, 0);
        @(negedge clk);
        rst = 1'b0;

        // lit pixel at row 3 col 14, dark neighbour at col 13
        applyStimulus(1'b0, 1'b1, 14, 3, 1'b1);
        checkOutput("t2_rom_addr", rom_addr, 3);
        applyStimulus(1'b0, 1'b1, 13, 3, 1'b1);
        checkOutput("t2_col14_on", pix_on, 1);
        applyStimulus(1'b0, 1'b1, 0, 0, 1'b0);
        checkOutput("t2_col13_off", pix_on, 0);

        // clipping just outside the box and with de low
        applyStimulus(1'b0, 1'b1, 128, 5, 1'b1);
        applyStimulus(1'b0, 1'b1, 20, 2047, 1'b1);
        checkOutput("t3_rom_hold", rom_addr, 3);
        applyStimulus(1'b0, 1'b1, 20, 5, 1'b0);
        checkOutput("t3_right_clip", pix_on, 0);
        applyStimulus(1'b0, 1'b1, 0, 0, 1'b0);
        checkOutput("t3_top_clip", pix_on, 0);
        applyStimulus(1'b0, 1'b1, 0, 0, 1'b0);
        checkOutput("t3_de_low", pix_on, 0);

        // divider: four enabled pulses give two updates, disabled pulses give none
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 0, 0, 1'b0);
            applyStimulus(1'b0, 1'b1, 0, 0, 1'b0);
        end
        checkOutput("t4_logo_x", logo_x, 2 * STEP);
        checkOutput("t4_logo_y", logo_y, 2 * STEP);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 0, 0, 1'b0);
            applyStimulus(1'b0, 1'b0, 0, 0, 1'b0);
        end
        checkOutput("t4_hold_x", logo_x, 2 * STEP);

        // long random sweep: long enough to hit both edges together on one update
        randomRun(20000);

        // asynchronous reset in the middle of a line
        randomRun(5);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_pix_on", pix_on, 0);
        checkOutput("midrst_de_out", pix_de_out, 0);
        checkOutput("midrst_rom_addr", rom_addr, 0);
        checkOutput("midrst_logo_x", logo_x, 0);
        checkOutput("midrst_logo_y", logo_y, 0);
        modelReset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        randomRun(2000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
